// File: rtl/lfsr_checker_if.sv
// Word stream and status bundle between a PRBS source and lfsr_checker.
interface lfsr_checker_if #(
  parameter int CNT_W = 16
) ();
  logic             in_valid;
  logic [9:0]       data_in;
  logic             clear_stats;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
  logic             period_tick;
  logic             period_err;

  modport master (
    output in_valid, data_in, clear_stats,
    input  locked, err_pulse, err_count, period_tick, period_err
  );

  modport slave (
    input  in_valid, data_in, clear_stats,
    output locked, err_pulse, err_count, period_tick, period_err
  );
endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the x^10 + x^7 + 1 PRBS word stream:
// hunts, locks, flywheels over corrupted words and checks the SEED period.
module lfsr_checker #(
  parameter logic [9:0] SEED       = 10'h26E,
  parameter int         LOCK_CNT   = 8,
  parameter int         UNLOCK_CNT = 4,
  parameter int         CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  lfsr_checker_if.slave bus
);

  localparam logic [1:0]  HUNT     = 2'd0;
  localparam logic [1:0]  SYNC     = 2'd1;
  localparam logic [1:0]  LOCK     = 2'd2;
  localparam logic [7:0]  LOCK_C   = 8'(LOCK_CNT);
  localparam logic [7:0]  UNLOCK_C = 8'(UNLOCK_CNT);
  localparam logic [10:0] PERIOD   = 11'd1023;

  logic [1:0]       state, state_nxt;
  logic [9:0]       ref_word, ref_nxt, pred;
  logic [7:0]       match_cnt, match_nxt;
  logic [7:0]       bad_run, bad_nxt;
  logic [10:0]      period_cnt, period_nxt;
  logic             armed, armed_nxt;
  logic             err_nxt, tick_nxt, perr_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             locked_q, err_q, tick_q, perr_q;
  logic             is_match, is_zero;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [10:0] sat_inc_period(input logic [10:0] v);
    return (&v) ? v : v + 11'd1;
  endfunction

  always_comb begin
    pred       = {ref_word[8:0], ref_word[9] ^ ref_word[6]};
    is_match   = (bus.data_in == pred);
    is_zero    = (bus.data_in == 10'd0);
    state_nxt  = state;
    ref_nxt    = ref_word;
    match_nxt  = match_cnt;
    bad_nxt    = bad_run;
    period_nxt = period_cnt;
    armed_nxt  = armed;
    err_nxt    = 1'b0;
    tick_nxt   = 1'b0;
    perr_nxt   = 1'b0;
    if (bus.in_valid) begin
      case (state)
        HUNT: begin
          if (!is_zero) begin
            ref_nxt   = bus.data_in;
            match_nxt = 8'd0;
            state_nxt = SYNC;
          end
        end
        SYNC: begin
          if (is_match) begin
            ref_nxt   = bus.data_in;
            match_nxt = match_cnt + 8'd1;
            if (match_nxt == LOCK_C) begin
              state_nxt  = LOCK;
              bad_nxt    = 8'd0;
              period_nxt = 11'd0;
              armed_nxt  = 1'b0;
            end
          end else if (is_zero) begin
            state_nxt = HUNT;
          end else begin
            ref_nxt   = bus.data_in;
            match_nxt = 8'd0;
          end
        end
        LOCK: begin
          period_nxt = sat_inc_period(period_cnt);
          if (is_match) begin
            ref_nxt = bus.data_in;
            bad_nxt = 8'd0;
            if (bus.data_in == SEED) begin
              tick_nxt   = 1'b1;
              perr_nxt   = armed && (period_cnt != PERIOD);
              period_nxt = 11'd1;
              armed_nxt  = 1'b1;
            end
          end else begin
            // Flywheel: keep the predicted word so one bad word cannot derail lock
            err_nxt = 1'b1;
            ref_nxt = pred;
            bad_nxt = bad_run + 8'd1;
            if (bad_nxt == UNLOCK_C) begin
              state_nxt = HUNT;
              armed_nxt = 1'b0;
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end

    // A same-cycle error outranks clear_stats, leaving a count of one
    if (err_nxt)
      cnt_nxt = bus.clear_stats ? CNT_W'(1) : sat_inc(cnt_q);
    else if (bus.clear_stats)
      cnt_nxt = '0;
    else
      cnt_nxt = cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      ref_word   <= 10'd0;
      match_cnt  <= 8'd0;
      bad_run    <= 8'd0;
      period_cnt <= 11'd0;
      armed      <= 1'b0;
      cnt_q      <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      tick_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      ref_word   <= ref_nxt;
      match_cnt  <= match_nxt;
      bad_run    <= bad_nxt;
      period_cnt <= period_nxt;
      armed      <= armed_nxt;
      cnt_q      <= cnt_nxt;
      locked_q   <= (state_nxt == LOCK);
      err_q      <= err_nxt;
      tick_q     <= tick_nxt;
      perr_q     <= perr_nxt;
    end
  end

  assign bus.locked      = locked_q;
  assign bus.err_pulse   = err_q;
  assign bus.err_count   = cnt_q;
  assign bus.period_tick = tick_q;
  assign bus.period_err  = perr_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomised bench for lfsr_checker: a position-based sequence model predicts
// every output each cycle, plus directed checks on lock, loss, period and stats.
module tb_lfsr_checker;

  localparam logic [9:0] SEED       = 10'h26E;
  localparam int         LOCK_CNT   = 8;
  localparam int         UNLOCK_CNT = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  lfsr_checker_if #(.CNT_W(16)) bus ();
  lfsr_checker_if #(.CNT_W(4))  bus4 ();

  lfsr_checker #(.SEED(SEED), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .CNT_W(16))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  lfsr_checker #(.SEED(SEED), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .CNT_W(4))
    dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Sequence as a table: seq[i] is the word i steps after SEED, pos[] is its inverse
  logic [9:0] seq [1023];
  int         pos [1024];
  int         g;

  // Model state, expressed as positions in the sequence rather than registers
  bit m_lk, m_armed, e_pulse, e_tick, e_perr;
  int m_streak, m_miss, m_since, m_pos, m_c16, m_c4;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int after(input int p);
    return (p + 1) % 1023;
  endfunction

  task automatic model_reset();
    m_lk = 0; m_armed = 0; e_pulse = 0; e_tick = 0; e_perr = 0;
    m_streak = 0; m_miss = 0; m_since = 0; m_pos = 0; m_c16 = 0; m_c4 = 0;
  endtask

  task automatic model_step(input logic v, input logic [9:0] d, input logic c);
    bit err = 0;
    e_tick = 0; e_perr = 0;
    if (v) begin
      if (!m_lk) begin
        if (m_streak == 0) begin
          if (d != 0) begin m_streak = 1; m_pos = pos[d]; end
        end else if (d != 0 && d == seq[after(m_pos)]) begin
          m_streak++;
          m_pos = pos[d];
          if (m_streak == LOCK_CNT + 1) begin
            m_lk = 1; m_miss = 0; m_armed = 0; m_since = 0;
          end
        end else if (d == 0) begin
          m_streak = 0;
        end else begin
          m_streak = 1; m_pos = pos[d];
        end
      end else begin
        m_since++;
        m_pos = after(m_pos);
        if (d == seq[m_pos]) begin
          m_miss = 0;
          if (m_pos == 0) begin
            e_tick  = 1;
            e_perr  = m_armed && (m_since != 1023);
            m_since = 0;
            m_armed = 1;
          end
        end else begin
          err = 1;
          m_miss++;
          if (m_miss == UNLOCK_CNT) begin m_lk = 0; m_streak = 0; m_armed = 0; end
        end
      end
    end
    e_pulse = err;
    if (err) begin
      m_c16 = c ? 1 : ((m_c16 < 65535) ? m_c16 + 1 : 65535);
      m_c4  = c ? 1 : ((m_c4 < 15) ? m_c4 + 1 : 15);
    end else if (c) begin
      m_c16 = 0; m_c4 = 0;
    end
  endtask

  task automatic drive(input logic v, input logic [9:0] d, input logic c);
    bus.in_valid = v;  bus.data_in = d;  bus.clear_stats = c;
    bus4.in_valid = v; bus4.data_in = d; bus4.clear_stats = c;
  endtask

  task automatic cyc(input logic v, input logic [9:0] d, input logic c);
    drive(v, d, c);
    @(posedge clk);
    model_step(v, d, c);
    #1;
    chk("locked", bus.locked, m_lk);
    chk("err_pulse", bus.err_pulse, e_pulse);
    chk("err_count", bus.err_count, m_c16);
    chk("period_tick", bus.period_tick, e_tick);
    chk("period_err", bus.period_err, e_perr);
    chk("locked_w4", bus4.locked, m_lk);
    chk("err_count_w4", bus4.err_count, m_c4);
  endtask

  task automatic send(input logic [9:0] mask, input logic c);
    cyc(1'b1, seq[g] ^ mask, c);
    g = after(g);
  endtask

  function automatic logic [9:0] rmask();
    return 10'($urandom_range(1023, 1));
  endfunction

  task automatic do_reset();
    drive(1'b0, 10'd0, 1'b0);
    rst_n = 1'b0;
    #2;
    model_reset();
    chk("rst_locked", bus.locked, 0);
    chk("rst_err_count", bus.err_count, 0);
    chk("rst_err_count_w4", bus4.err_count, 0);
    chk("rst_pulses", {bus.err_pulse, bus.period_tick, bus.period_err}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int ticks;
    logic [9:0] x;
    x = SEED;
    for (int i = 0; i < 1024; i++) pos[i] = -1;
    for (int i = 0; i < 1023; i++) begin
      seq[i] = x;
      pos[x] = i;
      x = {x[8:0], x[9] ^ x[6]};
    end
    #1;
    do_reset();

    // Clean lock from SEED and three full periods
    g = 0;
    repeat (8) send(10'd0, 1'b0);
    chk("lock_before_9th", bus.locked, 0);
    send(10'd0, 1'b0);
    chk("lock_after_9th", bus.locked, 1);
    ticks = 0;
    for (int i = 10; i <= 3070; i++) begin
      send(10'd0, 1'b0);
      if (bus.period_tick) ticks++;
    end
    chk("ticks_in_3_periods", ticks, 3);
    chk("clean_err_count", bus.err_count, 0);

    // Single-bit flip while locked
    send(10'd1 << $urandom_range(9, 0), 1'b0);
    chk("flip_pulse", bus.err_pulse, 1);
    chk("flip_count", bus.err_count, 1);
    chk("flip_locked", bus.locked, 1);
    repeat (20) send(10'd0, 1'b0);
    chk("flip_no_more_errs", bus.err_count, 1);

    // Loss of lock after UNLOCK_CNT bad words, then relock
    cyc(1'b0, 10'd0, 1'b1);
    repeat (3) send(rmask(), 1'b0);
    chk("lol_still_locked", bus.locked, 1);
    send(rmask(), 1'b0);
    chk("lol_count", bus.err_count, 4);
    chk("lol_dropped", bus.locked, 0);
    repeat (8) send(10'd0, 1'b0);
    chk("relock_early", bus.locked, 0);
    send(10'd0, 1'b0);
    chk("relock", bus.locked, 1);

    // Zero words in HUNT, then lock through random gaps
    do_reset();
    repeat (12) cyc(1'b1, 10'd0, 1'b0);
    chk("zero_stays_hunt", bus.locked, 0);
    g = $urandom_range(1022, 0);
    for (int k = 1; k <= 9; k++) begin
      repeat ($urandom_range(3, 1)) cyc(1'b0, 10'($urandom), 1'b0);
      if (k == 9) chk("gap_lock_early", bus.locked, 0);
      send(10'd0, 1'b0);
    end
    chk("gap_locked", bus.locked, 1);
    chk("gap_no_errs", bus.err_count, 0);

    // Period error: the SEED word of one period is corrupted
    while (g != 0) send(10'd0, 1'b0);
    send(10'd0, 1'b0);
    chk("seed_tick", bus.period_tick, 1);
    chk("first_seed_no_perr", bus.period_err, 0);
    while (g != 0) send(10'd0, 1'b0);
    send(rmask(), 1'b0);
    chk("lost_seed_pulse", bus.err_pulse, 1);
    chk("lost_seed_no_tick", bus.period_tick, 0);
    while (g != 0) send(10'd0, 1'b0);
    send(10'd0, 1'b0);
    chk("perr_tick", bus.period_tick, 1);
    chk("perr_flag", bus.period_err, 1);
    chk("perr_locked", bus.locked, 1);

    // Error together with clear_stats, then saturation of the narrow counter
    send(rmask(), 1'b1);
    chk("clear_with_err", bus.err_count, 1);
    repeat (20) begin
      send(rmask(), 1'b0);
      send(10'd0, 1'b0);
    end
    chk("sat_w4", bus4.err_count, 4'hF);
    chk("count_w16", bus.err_count, 21);

    // Random mix of clean, corrupted, zero, gap and clear cycles
    repeat (800) begin
      case ($urandom_range(19, 0))
        0:       cyc(1'b0, 10'($urandom), 1'b0);
        1:       send(rmask(), 1'b0);
        2:       cyc(1'b1, 10'd0, 1'b0);
        3:       send(($urandom_range(1, 0) != 0) ? rmask() : 10'd0, 1'b1);
        default: send(10'd0, 1'b0);
      endcase
    end

    // Asynchronous reset while locked with a nonzero count
    repeat (12) send(10'd0, 1'b0);
    send(10'd1, 1'b0);
    chk("pre_reset_locked", bus.locked, 1);
    do_reset();
    cyc(1'b0, 10'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
